// File: rtl/k68_sasc_loader.sv
// k68_sasc_loader: polls the k68 SASC UART, parses
// SYNC | A3..A0 | L1 L0 | N data | CSUM frames and
// writes the payload byte-wise to memory.
// Ports: clk_i, rst_i (async, active-low);
//   start_i/busy_o/done_o/err_o  core handshake;
//   u_add_o/u_dat_o/u_dat_i/u_cs_o/u_we_o  UART regs;
//   m_add_o/m_dat_o/m_we_o/m_ack_i  memory writes.
// Option: K68_LOADER_ECHO_EN echoes each received
//   byte back to the host; default build has no echo.

`ifndef k68_UART_ADR_DATA
`define k68_UART_ADR_DATA 16'h0000
`endif
`ifndef k68_UART_ADR_STATUS
`define k68_UART_ADR_STATUS 16'h0001
`endif

module k68_sasc_loader #(
  parameter logic [7:0] SYNC = 8'hA5,
  parameter int         AW   = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [15:0]   u_add_o,
  output logic [7:0]    u_dat_o,
  input  logic [7:0]    u_dat_i,
  output logic          u_cs_o,
  output logic          u_we_o,
  output logic [AW-1:0] m_add_o,
  output logic [7:0]    m_dat_o,
  output logic          m_we_o,
  input  logic          m_ack_i
);

  localparam logic [15:0] ADR_ST =
    `k68_UART_ADR_STATUS;
  localparam logic [15:0] ADR_DT =
    `k68_UART_ADR_DATA;

  typedef enum logic [3:0] {
    S_IDLE,
    S_POLL,
    S_PWAIT,
    S_RD,
    S_RWAIT,
    S_MEMW,
    S_FIN
`ifdef K68_LOADER_ECHO_EN
    ,
    S_ECHO_P,
    S_ECHO_W,
    S_ECHO_WR
`endif
  } state_t;

  typedef enum logic [2:0] {
    P_SYNC,
    P_ADDR,
    P_LEN,
    P_DATA,
    P_CSUM
  } phase_t;

  state_t        state;
  state_t        nxt;
  state_t        goal;
  phase_t        phase;
  logic [AW-1:0] addr;
  logic [15:0]   len;
  logic [15:0]   len_nx;
  logic [7:0]    sum;
  logic [7:0]    dbyte;
  logic [1:0]    cnt;

`ifdef K68_LOADER_ECHO_EN
  // where to resume once the echo is out
  state_t        ret;
`endif

  assign len_nx = {len[7:0], u_dat_i};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= S_IDLE;
      phase <= P_SYNC;
      addr  <= '0;
      len   <= '0;
      sum   <= '0;
      dbyte <= '0;
      cnt   <= '0;
`ifdef K68_LOADER_ECHO_EN
      ret   <= S_IDLE;
`endif
    end else begin
      state <= nxt;
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            phase <= P_SYNC;
            addr  <= '0;
            len   <= '0;
            sum   <= '0;
            cnt   <= '0;
          end
        end
        S_RWAIT: begin
          dbyte <= u_dat_i;
`ifdef K68_LOADER_ECHO_EN
          ret   <= goal;
`endif
          unique case (phase)
            P_SYNC: begin
              if (u_dat_i == SYNC) begin
                phase <= P_ADDR;
                cnt   <= '0;
              end
            end
            P_ADDR: begin
              addr <= {addr[AW-9:0], u_dat_i};
              cnt  <= cnt + 2'd1;
              if (cnt == 2'd3) begin
                phase <= P_LEN;
                cnt   <= '0;
              end
            end
            P_LEN: begin
              len <= len_nx;
              cnt <= cnt + 2'd1;
              if (cnt == 2'd1) begin
                cnt   <= '0;
                // empty payload skips to checksum
                phase <= (len_nx == 16'd0) ?
                         P_CSUM : P_DATA;
              end
            end
            P_DATA: sum <= sum + u_dat_i;
            default: ;
          endcase
        end
        S_MEMW: begin
          if (m_ack_i) begin
            addr <= addr + AW'(1);
            len  <= len - 16'd1;
            if (len == 16'd1)
              phase <= P_CSUM;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt     = state;
    goal    = S_POLL;
    busy_o  = (state != S_IDLE);
    done_o  = 1'b0;
    err_o   = 1'b0;
    u_add_o = '0;
    u_dat_o = '0;
    u_cs_o  = 1'b0;
    u_we_o  = 1'b0;
    m_add_o = '0;
    m_dat_o = '0;
    m_we_o  = 1'b0;
    unique case (phase)
      P_DATA:  goal = S_MEMW;
      P_CSUM:  goal = S_FIN;
      default: goal = S_POLL;
    endcase
    unique case (state)
      S_IDLE: begin
        if (start_i)
          nxt = S_POLL;
      end
      S_POLL: begin
        u_cs_o  = 1'b1;
        u_add_o = ADR_ST;
        nxt     = S_PWAIT;
      end
      S_PWAIT: begin
        nxt = u_dat_i[0] ? S_POLL : S_RD;
      end
      S_RD: begin
        u_cs_o  = 1'b1;
        u_add_o = ADR_DT;
        nxt     = S_RWAIT;
      end
      S_RWAIT: begin
`ifdef K68_LOADER_ECHO_EN
        nxt = S_ECHO_P;
`else
        nxt = goal;
`endif
      end
      S_MEMW: begin
        m_we_o  = 1'b1;
        m_add_o = addr;
        m_dat_o = dbyte;
        if (m_ack_i)
          nxt = S_POLL;
      end
      S_FIN: begin
        done_o = 1'b1;
        err_o  = (dbyte != sum);
        nxt    = S_IDLE;
      end
`ifdef K68_LOADER_ECHO_EN
      S_ECHO_P: begin
        u_cs_o  = 1'b1;
        u_add_o = ADR_ST;
        nxt     = S_ECHO_W;
      end
      S_ECHO_W: begin
        nxt = u_dat_i[1] ? S_ECHO_P : S_ECHO_WR;
      end
      S_ECHO_WR: begin
        u_cs_o  = 1'b1;
        u_we_o  = 1'b1;
        u_add_o = ADR_DT;
        u_dat_o = dbyte;
        nxt     = ret;
      end
`endif
      default: nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_k68_sasc_loader.sv
// tb_k68_sasc_loader: random and directed frames
// against a frame-level reference of the loader.

module tb_k68_sasc_loader;

  typedef logic [7:0] byte_t;

  localparam byte_t       SYNC   = 8'hA5;
  localparam logic [15:0] ADR_DT = 16'h0000;
  localparam logic [15:0] ADR_ST = 16'h0001;
`ifdef K68_LOADER_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [15:0] u_add_o;
  logic [7:0]  u_dat_o;
  logic [7:0]  u_dat_i;
  logic        u_cs_o;
  logic        u_we_o;
  logic [31:0] m_add_o;
  logic [7:0]  m_dat_o;
  logic        m_we_o;
  logic        m_ack_i;

  k68_sasc_loader #(.SYNC(SYNC), .AW(32)) dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .start_i (start_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .err_o   (err_o),
    .u_add_o (u_add_o),
    .u_dat_o (u_dat_o),
    .u_dat_i (u_dat_i),
    .u_cs_o  (u_cs_o),
    .u_we_o  (u_we_o),
    .m_add_o (m_add_o),
    .m_dat_o (m_dat_o),
    .m_we_o  (m_we_o),
    .m_ack_i (m_ack_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // host / UART / memory model state
  byte_t       rx_q[$];
  byte_t       echo_q[$];
  logic [31:0] wa_q[$];
  byte_t       wd_q[$];
  int          empty_hold = 0;
  int          full_hold  = 0;
  int          stall_once = -1;
  int          stall_cnt  = 0;
  bit          holding    = 0;
  logic [31:0] hold_a;
  byte_t       hold_d;
  bit          last_empty = 1;
  bit          last_full  = 0;
  bit          echo_pend  = 0;
  bit          prev_dcs   = 0;
  int          done_cnt   = 0;
  bit          err_last   = 0;
  bit          e_b;
  bit          f_b;

  always @(negedge clk) begin
    if (rst_n) begin
      if (u_cs_o && !u_we_o &&
          u_add_o == ADR_ST) begin
        e_b = (rx_q.size() == 0) ||
              (empty_hold > 0);
        if (empty_hold > 0) empty_hold--;
        f_b = echo_pend && (full_hold > 0);
        if (f_b) full_hold--;
        last_empty = e_b;
        last_full  = f_b;
        u_dat_i = {6'b0, f_b, e_b};
      end
      if (u_cs_o && !u_we_o &&
          u_add_o == ADR_DT) begin
        chk("rd_after_empty", 64'(last_empty), 0);
        chk("rd_b2b", 64'(prev_dcs), 0);
        last_empty = 1;
        if (rx_q.size() > 0) begin
          u_dat_i   = rx_q.pop_front();
          echo_pend = ECHO;
        end else begin
          chk("rd_nonempty", 0, 1);
          u_dat_i = 8'hEE;
        end
      end
      if (u_cs_o && u_we_o) begin
        chk("echo_full", 64'(last_full), 0);
        chk("echo_adr", 64'(u_add_o), 64'(ADR_DT));
        echo_q.push_back(u_dat_o);
        echo_pend = 0;
      end
      prev_dcs = u_cs_o && (u_add_o == ADR_DT);
      if (m_we_o) begin
        if (!holding) begin
          holding = 1;
          hold_a  = m_add_o;
          hold_d  = m_dat_o;
          if (stall_once >= 0) begin
            stall_cnt  = stall_once;
            stall_once = -1;
          end else begin
            stall_cnt = $urandom_range(0, 2);
          end
        end else begin
          chk("hold_a", 64'(m_add_o), 64'(hold_a));
          chk("hold_d", 64'(m_dat_o), 64'(hold_d));
        end
        if (stall_cnt > 0) begin
          stall_cnt--;
          m_ack_i = 0;
        end else begin
          m_ack_i = 1;
          wa_q.push_back(m_add_o);
          wd_q.push_back(m_dat_o);
          holding = 0;
        end
      end else begin
        holding = 0;
        // stray acks must be ignored
        m_ack_i = ($urandom_range(0, 3) == 0);
      end
      if (done_o) begin
        done_cnt++;
        err_last = err_o;
      end else if (err_o) begin
        chk("err_wo_done", 1, 0);
      end
    end
  end

  task automatic run_frame(input byte_t fr[$],
                           input int eh,
                           input int fh,
                           input int st);
    logic [31:0] ea_a[$];
    byte_t       ea_d[$];
    logic [31:0] a;
    int          n;
    int          i;
    int          d0;
    int          bud;
    byte_t       s;
    bit          ex_err;
    // reference: parse frame from the rules
    i = 0;
    while (fr[i] != SYNC) i++;
    i++;
    a = {fr[i], fr[i+1], fr[i+2], fr[i+3]};
    n = int'({fr[i+4], fr[i+5]});
    i += 6;
    s = 0;
    for (int k = 0; k < n; k++) begin
      ea_a.push_back(a + 32'(k));
      ea_d.push_back(fr[i+k]);
      s = s + fr[i+k];
    end
    ex_err = (fr[i+n] != s);
    wa_q.delete();
    wd_q.delete();
    echo_q.delete();
    empty_hold = eh;
    full_hold  = fh;
    stall_once = st;
    foreach (fr[k]) rx_q.push_back(fr[k]);
    d0  = done_cnt;
    bud = 400 + 80 * fr.size() + 4 * eh;
    @(negedge clk);
    #1 start_i = 1;
    @(negedge clk);
    #1 start_i = 0;
    chk("busy_arm", 64'(busy_o), 1);
    for (int c = 0; c < bud && done_cnt == d0;
         c++) begin
      @(negedge clk);
      #1 start_i = (c == 4);
    end
    chk("done_once", 64'(done_cnt - d0), 1);
    chk("busy_fin", 64'(busy_o), 1);
    // start on the FIN cycle is ignored
    start_i = 1;
    @(negedge clk);
    #1 start_i = 0;
    chk("busy_drop", 64'(busy_o), 0);
    @(negedge clk);
    chk("busy_idle", 64'(busy_o), 0);
    chk("err", 64'(err_last), 64'(ex_err));
    chk("rx_left", 64'(rx_q.size()), 0);
    chk("nwr", 64'(wa_q.size()), 64'(ea_a.size()));
    for (int k = 0; k < ea_a.size() &&
         k < wa_q.size(); k++) begin
      chk("wr_a", 64'(wa_q[k]), 64'(ea_a[k]));
      chk("wr_d", 64'(wd_q[k]), 64'(ea_d[k]));
    end
    chk("necho", 64'(echo_q.size()),
        ECHO ? 64'(fr.size()) : 64'(0));
    if (ECHO) begin
      for (int k = 0; k < fr.size() &&
           k < echo_q.size(); k++)
        chk("echo_d", 64'(echo_q[k]), 64'(fr[k]));
    end
  endtask

  byte_t       fr[$];
  byte_t       b;
  byte_t       s;
  logic [31:0] a;
  int          n;

  initial begin
    rst_n   = 0;
    start_i = 0;
    u_dat_i = 0;
    m_ack_i = 0;
    #1;
    chk("rst_outs",
        {busy_o, done_o, err_o, u_add_o, u_dat_o,
         u_cs_o, u_we_o, m_we_o, m_dat_o}, 0);
    chk("rst_madd", 64'(m_add_o), 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 64'(busy_o), 0);

    fr = '{8'hA5, 8'h00, 8'h00, 8'h10, 8'h00,
           8'h00, 8'h03, 8'h11, 8'h22, 8'h33,
           8'h66};
    run_frame(fr, 0, 0, -1);

    // reset while a memory write is pending
    foreach (fr[k]) rx_q.push_back(fr[k]);
    stall_once = 20;
    @(negedge clk);
    #1 start_i = 1;
    @(negedge clk);
    #1 start_i = 0;
    for (int k = 0; k < 500 && !m_we_o; k++)
      @(negedge clk);
    chk("memw_seen", 64'(m_we_o), 1);
    #2 rst_n = 0;
    #1;
    chk("mrst_outs",
        {busy_o, done_o, err_o, u_add_o, u_dat_o,
         u_cs_o, u_we_o, m_we_o, m_dat_o}, 0);
    chk("mrst_madd", 64'(m_add_o), 0);
    rx_q.delete();
    wa_q.delete();
    wd_q.delete();
    echo_q.delete();
    holding    = 0;
    stall_cnt  = 0;
    stall_once = -1;
    echo_pend  = 0;
    last_empty = 1;
    prev_dcs   = 0;
    m_ack_i    = 0;
    @(negedge clk);
    chk("mrst_busy", 64'(busy_o), 0);
    rst_n = 1;
    run_frame(fr, 0, 0, -1);

    // bad checksum
    fr[10] = 8'h67;
    run_frame(fr, 0, 0, -1);

    // junk before sync, empty payload
    fr = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00,
           8'h00, 8'h20, 8'h00, 8'h00, 8'h00};
    run_frame(fr, 0, 0, -1);

    // long empty, long ack stall, full on echo
    fr = '{8'hA5, 8'h00, 8'h00, 8'h10, 8'h00,
           8'h00, 8'h03, 8'h11, 8'h22, 8'h33,
           8'h66};
    run_frame(fr, 50, 0, 7);
    run_frame(fr, 0, 3, -1);

    for (int t = 0; t < 24; t++) begin
      fr.delete();
      repeat ($urandom_range(0, 3)) begin
        b = byte_t'($urandom);
        if (b == SYNC) b = 8'h00;
        fr.push_back(b);
      end
      fr.push_back(SYNC);
      if ($urandom_range(0, 3) == 0)
        a = 32'hFFFF_FFFF -
            32'($urandom_range(0, 3));
      else
        a = $urandom;
      fr.push_back(a[31:24]);
      fr.push_back(a[23:16]);
      fr.push_back(a[15:8]);
      fr.push_back(a[7:0]);
      n = $urandom_range(0, 8);
      fr.push_back(8'(n >> 8));
      fr.push_back(8'(n));
      s = 0;
      for (int k = 0; k < n; k++) begin
        b = byte_t'($urandom);
        s = s + b;
        fr.push_back(b);
      end
      if ($urandom_range(0, 3) == 0)
        s = s + 8'($urandom_range(1, 255));
      fr.push_back(s);
      run_frame(fr, $urandom_range(0, 5),
                $urandom_range(0, 2), -1);
    end

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
